dma_controller: RTL and testbench

- Moves a fixed-length block of words from an external device buffer into main memory on behalf of the CPU.
- Requests the memory bus from the CPU with BR and waits for BG before doing anything on the bus.
- Gathers BLOCK_WORDS words from the device, then issues one block write to memory, and repeats until the transfer is complete.
- Publishes dma_counter, which the CPU hazard/stall logic compares against DMA_LENGTH-1 (=11) to leave its interrupt stall.

---
 rtl/dma_if.sv | 33 +++
 rtl/dma_controller.sv | 125 ++++++++++++
 tb/tb_dma_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_if.sv
// Bus bundle between the DMA engine and its CPU, device and memory neighbours.
// The master side is the DMA controller; the slave side is whatever drives it.
interface dma_if #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4
);
  logic                          cmd_valid;
  logic [WORD_SIZE-1:0]          cmd_addr;
  logic                          cmd_ready;
  logic                          BR;
  logic                          BG;
  logic                          dev_req;
  logic [3:0]                    dev_offset;
  logic [WORD_SIZE-1:0]          dev_data;
  logic                          mem_write;
  logic [WORD_SIZE-1:0]          mem_addr;
  logic [BLOCK_WORDS*WORD_SIZE-1:0] mem_data;
  logic                          mem_ready;
  logic [3:0]                    dma_counter;
  logic                          dma_done;

  modport master (
    input  cmd_valid, cmd_addr, BG, dev_data, mem_ready,
    output cmd_ready, BR, dev_req, dev_offset, mem_write, mem_addr, mem_data,
           dma_counter, dma_done
  );

  modport slave (
    output cmd_valid, cmd_addr, BG, dev_data, mem_ready,
    input  cmd_ready, BR, dev_req, dev_offset, mem_write, mem_addr, mem_data,
           dma_counter, dma_done
  );
endinterface

// File: rtl/dma_controller.sv
// Block-gathering DMA engine: pulls DMA_LENGTH device words, BLOCK_WORDS at a time,
// and commits each block to memory with a single write while holding the bus.
module dma_controller #(
  parameter int WORD_SIZE   = 16,
  parameter int DMA_LENGTH  = 12,
  parameter int BLOCK_WORDS = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  dma_if.master  bus
);

  localparam int OFFS_W     = $clog2(BLOCK_WORDS);
  localparam int NUM_BURSTS = DMA_LENGTH / BLOCK_WORDS;
  localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [WORD_SIZE-1:0] ADDR_MASK = ~WORD_SIZE'((1 << OFFS_W) - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GATHER,
    WRITE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WORD_SIZE-1:0] base;
  logic [3:0]           index;
  logic [BURST_W-1:0]   burst;
  logic [3:0]           counter;
  logic [WORD_SIZE-1:0] buffer [BLOCK_WORDS];

  logic accept, capture, commit, slot_last, burst_last;

  assign accept     = (state == IDLE)   && bus.cmd_valid;
  assign capture    = (state == GATHER) && bus.BG;
  assign commit     = (state == WRITE)  && bus.BG && bus.mem_ready;
  assign slot_last  = index[OFFS_W-1:0] == OFFS_W'(BLOCK_WORDS - 1);
  assign burst_last = burst == BURST_W'(NUM_BURSTS - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.cmd_valid)        state_next = REQ;
      REQ:     if (bus.BG)               state_next = GATHER;
      GATHER:  if (capture && slot_last) state_next = WRITE;
      WRITE:   if (commit)               state_next = burst_last ? DONE : GATHER;
      DONE:                              state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Bus-facing strobes; dev_req and mem_write follow BG so a withdrawn grant
  // stalls the bus in the same cycle.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    bus.cmd_ready = 1'b0;
    bus.BR        = 1'b0;
    bus.dev_req   = 1'b0;
    bus.mem_write = 1'b0;
    bus.dma_done  = 1'b0;
    unique case (state)
      IDLE:   bus.cmd_ready = 1'b1;
      REQ:    bus.BR        = 1'b1;
      GATHER: begin
        bus.BR      = 1'b1;
        bus.dev_req = bus.BG;
      end
      WRITE: begin
        bus.BR        = 1'b1;
        bus.mem_write = bus.BG;
      end
      DONE:   bus.dma_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base    <= '0;
      index   <= '0;
      burst   <= '0;
      counter <= '0;
      // NOTE: the gather buffer is only BLOCK_WORDS registers, so it is reset
      // like the rest; mem_data must read zero straight out of reset.
      for (int i = 0; i < BLOCK_WORDS; i++) buffer[i] <= '0;
    end else begin
      if (accept) begin
        base    <= bus.cmd_addr & ADDR_MASK;
        index   <= '0;
        burst   <= '0;
        counter <= '0;
      end
      if (capture) begin
        buffer[index[OFFS_W-1:0]] <= bus.dev_data;
        index                     <= index + 4'd1;
      end
      // The final commit reports DMA_LENGTH-1, the value the CPU stall logic waits for.
      if (commit) begin
        burst   <= burst + BURST_W'(1);
        counter <= burst_last ? 4'(DMA_LENGTH - 1) : counter + 4'(BLOCK_WORDS);
      end
    end
  end

  assign bus.dev_offset  = index;
  assign bus.dma_counter = counter;
  assign bus.mem_addr    = base + (WORD_SIZE'(burst) << OFFS_W);

  always_comb begin
    bus.mem_data = '0;
    for (int i = 0; i < BLOCK_WORDS; i++)
      bus.mem_data[i*WORD_SIZE +: WORD_SIZE] = buffer[i];
  end

endmodule

// File: tb/tb_dma_controller.sv
// Randomised bench for dma_controller: a transfer-level model (words gathered,
// blocks committed) predicts every strobe and bus value on every cycle.
module tb_dma_controller;

  localparam int W   = 16;
  localparam int BW  = 4;
  localparam int LEN = 12;

  logic clk = 1'b0;
  logic reset_n;

  dma_if #(.WORD_SIZE(W), .BLOCK_WORDS(BW)) bus ();

  dma_controller #(.WORD_SIZE(W), .DMA_LENGTH(LEN), .BLOCK_WORDS(BW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  logic [W-1:0] dev_mem [16];
  assign bus.dev_data = dev_mem[bus.dev_offset];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model state
  bit           m_busy, m_granted, m_done;
  int           m_words, m_bursts;
  logic [W-1:0] m_base;
  logic [3:0]   m_cnt;

  // Observation logs for the hand-computed expectations
  logic [W-1:0]  addr_log [$];
  logic [63:0]   data_log [$];
  logic [3:0]    off_log  [$];
  logic [3:0]    cnt_log  [$];
  int cyc = 0, acc_cyc = 0, done_cyc = 0, done_count = 0, early = 0;
  logic br_at_done;

  function automatic void model_reset();
    m_busy = 0; m_granted = 0; m_done = 0;
    m_words = 0; m_bursts = 0; m_base = '0; m_cnt = '0;
  endfunction

  function automatic logic [63:0] block_of(input int b);
    logic [63:0] r;
    for (int i = 0; i < BW; i++) r[i*W +: W] = dev_mem[b*BW + i];
    return r;
  endfunction

  initial begin : compare
    logic exp_req, exp_wr;
    logic [3:0] last_cnt;
    last_cnt = '0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset();
      exp_req = m_busy && m_granted && bus.BG && (m_words <  (m_bursts + 1) * BW);
      exp_wr  = m_busy && m_granted && bus.BG && (m_words == (m_bursts + 1) * BW);
      check("cmd_ready",   64'(bus.cmd_ready),   64'(!m_busy && !m_done));
      check("BR",          64'(bus.BR),          64'(m_busy));
      check("dev_req",     64'(bus.dev_req),     64'(exp_req));
      check("mem_write",   64'(bus.mem_write),   64'(exp_wr));
      check("dma_done",    64'(bus.dma_done),    64'(m_done));
      check("dma_counter", 64'(bus.dma_counter), 64'(m_cnt));
      if (exp_req) check("dev_offset", 64'(bus.dev_offset), 64'(m_words));
      if (exp_wr) begin
        check("mem_addr", 64'(bus.mem_addr), 64'(W'(m_base + W'(m_bursts * BW))));
        check("mem_data", bus.mem_data, block_of(m_bursts));
      end
      if (!reset_n) begin
        check("rst_dev_offset", 64'(bus.dev_offset), 64'(0));
        check("rst_mem_addr",   64'(bus.mem_addr),   64'(0));
        check("rst_mem_data",   bus.mem_data,        64'(0));
      end
      if ((bus.dev_req || bus.mem_write) && !bus.BG) early++;
      if (bus.dev_req) off_log.push_back(bus.dev_offset);
      if (bus.dma_counter != last_cnt) begin
        cnt_log.push_back(bus.dma_counter);
        last_cnt = bus.dma_counter;
      end
      if (bus.dma_done) begin
        done_cyc = cyc; br_at_done = bus.BR; done_count++;
      end

      @(posedge clk);
      cyc++;
      if (!reset_n) model_reset();
      else if (m_done) m_done = 0;
      else if (!m_busy) begin
        if (bus.cmd_valid) begin
          m_busy = 1; m_granted = 0; m_words = 0; m_bursts = 0; m_cnt = '0;
          m_base = bus.cmd_addr & 16'hFFFC;
          acc_cyc = cyc;
        end
      end
      else if (!m_granted) begin
        if (bus.BG) m_granted = 1;
      end
      else if (exp_req) m_words++;
      else if (exp_wr && bus.mem_ready) begin
        addr_log.push_back(bus.mem_addr);
        data_log.push_back(bus.mem_data);
        m_bursts++;
        if (m_bursts == LEN / BW) begin
          m_busy = 0; m_done = 1; m_cnt = 4'(LEN - 1);
        end else m_cnt = 4'(m_bursts * BW);
      end
    end
  end

  task automatic clear_logs();
    addr_log.delete(); data_log.delete(); off_log.delete(); cnt_log.delete();
  endtask

  // One command, then per-cycle BG / mem_ready / cmd_valid policy until dma_done.
  task automatic transfer(input logic [W-1:0] addr, input int bg_delay, input int gap_at,
                          input int gap_len, input int mem_delay, input bit rnd,
                          input bit inject, input bit do_reset);
    int commits = 0, gap_left = 0, wcnt = 0, delay_left = bg_delay, steps = 0;
    bit gapped = 0, injected = 0, fin = 0;
    for (int i = 0; i < 16; i++) dev_mem[i] = W'($urandom);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.BG        = rnd ? 1'($urandom_range(0, 1)) : 1'(bg_delay == 0);
    bus.mem_ready = 1'b0;
    while (!fin && steps < 400) begin
      @(posedge clk); #1;
      steps++;
      bus.cmd_valid = 1'b0;
      bus.mem_ready = 1'b0;
      if (bus.dma_done) fin = 1;
      else begin
        if (delay_left > 0) begin
          delay_left--;
          bus.BG = 1'(delay_left == 0);
        end
        else if (rnd) bus.BG = 1'($urandom_range(0, 3) != 0);
        else if (gap_left > 0) gap_left--;
        else if (!gapped && gap_at >= 0 && bus.dev_req && int'(bus.dev_offset) == gap_at) begin
          bus.BG = 1'b0; gap_left = gap_len - 1; gapped = 1;
        end
        else bus.BG = 1'b1;
        if (rnd && $urandom_range(0, 7) == 0) begin
          bus.cmd_valid = 1'b1; bus.cmd_addr = W'($urandom);
        end
        if (inject && !injected && commits == 1 && bus.dev_req) begin
          bus.cmd_valid = 1'b1; bus.cmd_addr = 16'h2000; injected = 1;
        end
        #1;
        if (do_reset && commits == 1 && bus.mem_write) begin
          reset_n = 1'b0; fin = 1;
        end
        else if (bus.mem_write) begin
          bus.mem_ready = rnd ? 1'($urandom_range(0, 2) == 0) : 1'(wcnt == mem_delay);
          wcnt++;
        end
        else begin
          wcnt = 0;
          if (rnd) bus.mem_ready = 1'($urandom_range(0, 2) == 0);
        end
        if (bus.mem_ready && bus.mem_write) begin
          commits++; wcnt = 0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    check("transfer_end", 64'(fin), 64'(1));
    if (!do_reset) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] nom_addr [3];
    logic [3:0]   nom_cnt  [3];
    logic [W-1:0] wrap_addr[3];
    int done_before;
    nom_addr  = '{16'h0100, 16'h0104, 16'h0108};
    nom_cnt   = '{4'd4, 4'd8, 4'd11};
    wrap_addr = '{16'hFFFC, 16'h0000, 16'h0004};

    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.BG = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) dev_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", 64'(bus.cmd_ready),   64'(1));
    check("reset_counter",   64'(bus.dma_counter), 64'(0));
    reset_n = 1'b1;

    // Nominal
    clear_logs();
    transfer(16'h0103, 0, -1, 0, 0, 0, 0, 0);
    check("nom_addr_count", 64'(addr_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < addr_log.size(); i++) check("nom_addr", 64'(addr_log[i]), 64'(nom_addr[i]));
    check("nom_cnt_count", 64'(cnt_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < cnt_log.size(); i++) check("nom_counter_seq", 64'(cnt_log[i]), 64'(nom_cnt[i]));
    check("nom_offset_count", 64'(off_log.size()), 64'(12));
    for (int i = 0; i < off_log.size(); i++) check("nom_offset_seq", 64'(off_log[i]), 64'(i));
    check("nom_latency", 64'(done_cyc - acc_cyc), 64'(16));
    check("nom_BR_at_done", 64'(br_at_done), 64'(0));

    // Grant delayed by 5 cycles
    transfer(16'h1235, 5, -1, 0, 0, 0, 0, 0);

    // Grant withdrawn for 3 cycles at index 6
    clear_logs();
    transfer(16'h0A00, 0, 6, 3, 0, 0, 0, 0);
    check("gap_offset_count", 64'(off_log.size()), 64'(12));
    check("gap_burst1_data", data_log.size() > 1 ? data_log[1] : 64'hDEAD,
          {dev_mem[7], dev_mem[6], dev_mem[5], dev_mem[4]});

    // Slow memory
    clear_logs();
    transfer(16'h0040, 0, -1, 0, 7, 0, 0, 0);
    check("slow_cnt_count", 64'(cnt_log.size()), 64'(4));
    if (cnt_log.size() == 4) begin
      check("slow_cnt0", 64'(cnt_log[0]), 64'(0));
      check("slow_cnt3", 64'(cnt_log[3]), 64'(11));
    end

    // Command during second burst must be ignored
    clear_logs();
    transfer(16'h3453, 0, -1, 0, 0, 0, 1, 0);
    check("inject_addr_count", 64'(addr_log.size()), 64'(3));
    if (addr_log.size() == 3) check("inject_addr2", 64'(addr_log[2]), 64'(16'h3458));

    // Address wrap
    clear_logs();
    transfer(16'hFFFE, 0, -1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3 && i < addr_log.size(); i++) check("wrap_addr", 64'(addr_log[i]), 64'(wrap_addr[i]));

    // Reset during the second block write
    done_before = done_count;
    transfer(16'h0200, 0, -1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("abort_BR",        64'(bus.BR),          64'(0));
    check("abort_mem_write", 64'(bus.mem_write),   64'(0));
    check("abort_counter",   64'(bus.dma_counter), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_no_done", 64'(done_count), 64'(done_before));
    clear_logs();
    transfer(16'h0300, 0, -1, 0, 0, 0, 0, 0);
    check("after_abort_done", 64'(done_count), 64'(done_before + 1));
    check("after_abort_blocks", 64'(addr_log.size()), 64'(3));

    // Random grant, memory and command traffic
    for (int t = 0; t < 10; t++) transfer(W'($urandom), 0, -1, 0, 0, 1, 0, 0);

    check("no_bus_activity_without_BG", 64'(early), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
